// File: rtl/otter_mem_arb_if.sv
// ============================================================================
//  Module   : otter_mem_arb_if
//  Brief    : Bus bundle for the OTTER memory arbiter. It carries both requester
//             ports and the shared memory port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface otter_mem_arb_if #(
  parameter int ADDR_W = 32
);
  // Port 1: instruction fetch (read-only)
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       rdata1;
  logic              ack1;
  logic              err1;

  // Port 2: data (read/write)
  logic              req2;
  logic              we2;
  logic [ADDR_W-1:0] addr2;
  logic [31:0]       wdata2;
  logic [3:0]        be2;
  logic [31:0]       rdata2;
  logic              ack2;
  logic              err2;

  // Shared memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  // Requesters and memory side (drives requests and memory responses)
  modport master (
    output req1, addr1, req2, we2, addr2, wdata2, be2, mem_rdata, mem_ready,
    input  rdata1, ack1, err1, rdata2, ack2, err2,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Arbiter side
  modport slave (
    input  req1, addr1, req2, we2, addr2, wdata2, be2, mem_rdata, mem_ready,
    output rdata1, ack1, err1, rdata2, ack2, err2,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

`default_nettype wire

// File: rtl/otter_mem_arb.sv
// ============================================================================
//  Module   : otter_mem_arb
//  Brief    : Two-port memory arbiter. Port 2 (data) normally has priority.
//             Port 1 (fetch) is guaranteed a grant after STARVE_MAX
//             consecutive port-2 wins. Each access is bounded by TIMEOUT_CYC.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module otter_mem_arb #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  parameter int STARVE_MAX  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  otter_mem_arb_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT1 = 2'd1;
  localparam logic [1:0] ST_GNT2 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // The wait count reaching this value means the current cycle is the last allowed one
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]        state_q,     state_d;
  logic [3:0]        starve_q,    starve_d;
  logic [7:0]        wait_q,      wait_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q,    mem_be_d;
  logic [31:0]       rdata1_q,    rdata1_d;
  logic [31:0]       rdata2_q,    rdata2_d;
  logic              ack1_q,      ack1_d;
  logic              ack2_q,      ack2_d;
  logic              err1_q,      err1_d;
  logic              err2_q,      err2_d;
  logic              pick_port1;

  // Next-state logic: grant decision, memory handshake, timeout and completion
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    ack1_d      = 1'b0;
    ack2_d      = 1'b0;
    err1_d      = 1'b0;
    err2_d      = 1'b0;
    pick_port1  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req1 || bus.req2) begin
          // Port 2 wins a tie unless port 1 has been passed over STARVE_MAX times
          pick_port1 = bus.req1 && (!bus.req2 || (starve_q == STARVE_LIM));
          wait_d     = 8'd0;
          mem_req_d  = 1'b1;
          if (pick_port1) begin
            state_d     = ST_GNT1;
            starve_d    = 4'd0;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.addr1;
            mem_wdata_d = 32'h0;
            mem_be_d    = 4'hF;
          end else begin
            state_d     = ST_GNT2;
            if (bus.req1) begin
              starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
            end else begin
              starve_d = 4'd0;
            end
            mem_we_d    = bus.we2;
            mem_addr_d  = bus.addr2;
            mem_wdata_d = bus.wdata2;
            mem_be_d    = bus.be2;
          end
        end
      end

      ST_GNT1, ST_GNT2: begin
        if (bus.mem_ready) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (state_q == ST_GNT1) begin
            ack1_d   = 1'b1;
            rdata1_d = bus.mem_rdata;
          end else begin
            ack2_d = 1'b1;
            if (!mem_we_q) begin
              rdata2_d = bus.mem_rdata;
            end
          end
        end else if (wait_q == WAIT_LAST) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (state_q == ST_GNT1) begin
            ack1_d   = 1'b1;
            err1_d   = 1'b1;
            rdata1_d = 32'h0;
          end else begin
            ack2_d   = 1'b1;
            err2_d   = 1'b1;
            rdata2_d = 32'h0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: begin
        // DONE: one-cycle completion slot, requests and mem_ready ignored
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset that aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      starve_q    <= 4'd0;
      wait_q      <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      rdata1_q    <= 32'h0;
      rdata2_q    <= 32'h0;
      ack1_q      <= 1'b0;
      ack2_q      <= 1'b0;
      err1_q      <= 1'b0;
      err2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      ack1_q      <= ack1_d;
      ack2_q      <= ack2_d;
      err1_q      <= err1_d;
      err2_q      <= err2_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.rdata2    = rdata2_q;
  assign bus.ack1      = ack1_q;
  assign bus.ack2      = ack2_q;
  assign bus.err1      = err1_q;
  assign bus.err2      = err2_q;

endmodule

`default_nettype wire

// File: tb/tb_otter_mem_arb.sv
// ============================================================================
//  Module   : tb_otter_mem_arb
//  Brief    : Directed bench for otter_mem_arb. It uses per-cycle vectors plus
//             sequences for starvation, timeout and reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_otter_mem_arb;

  typedef struct {
    logic        r1;   logic [31:0] a1;
    logic        r2;   logic        w2;  logic [31:0] a2; logic [31:0] wd2; logic [3:0] b2;
    logic        rdy;  logic [31:0] rd;
    logic        mreq; logic        mwe; logic [31:0] maddr; logic [31:0] mwd; logic [3:0] mbe;
    logic        ak1;  logic        ak2; logic        er1;   logic        er2;
    logic [31:0] rd1;  logic [31:0] rd2;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  otter_mem_arb_if #(.ADDR_W(32)) bus ();

  otter_mem_arb #(.ADDR_W(32), .TIMEOUT_CYC(16), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    logic r1, logic [31:0] a1, logic r2, logic w2, logic [31:0] a2, logic [31:0] wd2,
    logic [3:0] b2, logic rdy, logic [31:0] rd, logic mreq, logic mwe, logic [31:0] maddr,
    logic [31:0] mwd, logic [3:0] mbe, logic ak1, logic ak2, logic er1, logic er2,
    logic [31:0] rd1, logic [31:0] rd2);
    vec_t v;
    v.r1 = r1; v.a1 = a1; v.r2 = r2; v.w2 = w2; v.a2 = a2; v.wd2 = wd2; v.b2 = b2;
    v.rdy = rdy; v.rd = rd; v.mreq = mreq; v.mwe = mwe; v.maddr = maddr; v.mwd = mwd;
    v.mbe = mbe; v.ak1 = ak1; v.ak2 = ak2; v.er1 = er1; v.er2 = er2; v.rd1 = rd1; v.rd2 = rd2;
    return v;
  endfunction

  // Waits for a grant, answers it with mem_ready and checks the matching ack
  task automatic serve(output int port, input logic [31:0] rd);
    port = 0;
    for (int k = 0; k < 20 && !bus.mem_req; k++) tick();
    chk("serve_grant_seen", {31'b0, bus.mem_req}, 32'd1);
    if (bus.mem_req) begin
      port = (bus.mem_addr == 32'h400) ? 1 : ((bus.mem_addr == 32'h500) ? 2 : 0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = rd;
      tick();
      bus.mem_ready = 1'b0;
      chk("serve_ack_excl", {31'b0, bus.ack1 & bus.ack2}, 32'd0);
      chk("serve_ack_port", {30'b0, bus.ack2, bus.ack1}, (port == 1) ? 32'd1 : 32'd2);
    end
  endtask

  vec_t vecs[14];
  int   port;
  int   cnt;

  initial begin
    bus.req1 = 0; bus.addr1 = 0; bus.req2 = 0; bus.we2 = 0; bus.addr2 = 0;
    bus.wdata2 = 0; bus.be2 = 0; bus.mem_ready = 0; bus.mem_rdata = 0;

    //            r1 a1     r2 w2 a2     wd2          b2    rdy rd            | mreq mwe maddr  mwd          mbe  ak1 ak2 er1 er2 rd1           rd2
    vecs[0]  = mk(1, 'h100, 0, 0, 0,     0,           4'h0, 0, 0,              1, 0, 'h100, 0,           4'hF, 0, 0, 0, 0, 0,            0);
    vecs[1]  = mk(1, 'h100, 0, 0, 0,     0,           4'h0, 1, 'h12345678,     0, 0, 'h100, 0,           4'hF, 1, 0, 0, 0, 'h12345678,   0);
    vecs[2]  = mk(0, 0,     0, 0, 0,     0,           4'h0, 0, 0,              0, 0, 'h100, 0,           4'hF, 0, 0, 0, 0, 'h12345678,   0);
    vecs[3]  = mk(1, 'h104, 1, 1, 'h200, 'hCAFEF00D, 4'h3, 0, 0,              1, 1, 'h200, 'hCAFEF00D, 4'h3, 0, 0, 0, 0, 'h12345678,   0);
    vecs[4]  = mk(1, 'h104, 1, 1, 'h200, 'hCAFEF00D, 4'h3, 1, 'hDEADBEEF,     0, 1, 'h200, 'hCAFEF00D, 4'h3, 0, 1, 0, 0, 'h12345678,   0);
    vecs[5]  = mk(1, 'h104, 0, 0, 0,     0,           4'h0, 0, 0,              0, 1, 'h200, 'hCAFEF00D, 4'h3, 0, 0, 0, 0, 'h12345678,   0);
    vecs[6]  = mk(1, 'h104, 0, 0, 0,     0,           4'h0, 0, 0,              1, 0, 'h104, 0,           4'hF, 0, 0, 0, 0, 'h12345678,   0);
    vecs[7]  = mk(1, 'h104, 0, 0, 0,     0,           4'h0, 1, 'h0BADF00D,     0, 0, 'h104, 0,           4'hF, 1, 0, 0, 0, 'h0BADF00D,   0);
    vecs[8]  = mk(0, 0,     0, 0, 0,     0,           4'h0, 1, 'h11111111,     0, 0, 'h104, 0,           4'hF, 0, 0, 0, 0, 'h0BADF00D,   0);
    vecs[9]  = mk(0, 0,     0, 0, 0,     0,           4'h0, 1, 'hFFFFFFFF,     0, 0, 'h104, 0,           4'hF, 0, 0, 0, 0, 'h0BADF00D,   0);
    vecs[10] = mk(0, 0,     1, 0, 'h300, 'h55,        4'hF, 0, 0,              1, 0, 'h300, 'h55,        4'hF, 0, 0, 0, 0, 'h0BADF00D,   0);
    vecs[11] = mk(0, 0,     1, 0, 'h300, 'h55,        4'hF, 0, 0,              1, 0, 'h300, 'h55,        4'hF, 0, 0, 0, 0, 'h0BADF00D,   0);
    vecs[12] = mk(0, 0,     1, 0, 'h300, 'h55,        4'hF, 1, 'hA5A5A5A5,     0, 0, 'h300, 'h55,        4'hF, 0, 1, 0, 0, 'h0BADF00D,   'hA5A5A5A5);
    vecs[13] = mk(0, 0,     0, 0, 0,     0,           4'h0, 0, 0,              0, 0, 'h300, 'h55,        4'hF, 0, 0, 0, 0, 'h0BADF00D,   'hA5A5A5A5);

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_mem_req",   {31'b0, bus.mem_req}, 0);
    chk("rst_mem_we",    {31'b0, bus.mem_we},  0);
    chk("rst_mem_addr",  bus.mem_addr,  0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_be",    {28'b0, bus.mem_be}, 0);
    chk("rst_acks_errs", {28'b0, bus.ack1, bus.ack2, bus.err1, bus.err2}, 0);
    chk("rst_rdata1",    bus.rdata1, 0);
    chk("rst_rdata2",    bus.rdata2, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Cycle vectors: inputs applied before an edge, outputs checked after it
    for (int i = 0; i < 14; i++) begin
      bus.req1 = vecs[i].r1; bus.addr1 = vecs[i].a1;
      bus.req2 = vecs[i].r2; bus.we2 = vecs[i].w2; bus.addr2 = vecs[i].a2;
      bus.wdata2 = vecs[i].wd2; bus.be2 = vecs[i].b2;
      bus.mem_ready = vecs[i].rdy; bus.mem_rdata = vecs[i].rd;
      tick();
      chk($sformatf("v%0d_mem_req", i),   {31'b0, bus.mem_req}, {31'b0, vecs[i].mreq});
      chk($sformatf("v%0d_mem_we", i),    {31'b0, bus.mem_we},  {31'b0, vecs[i].mwe});
      chk($sformatf("v%0d_mem_addr", i),  bus.mem_addr,  vecs[i].maddr);
      chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vecs[i].mwd);
      chk($sformatf("v%0d_mem_be", i),    {28'b0, bus.mem_be}, {28'b0, vecs[i].mbe});
      chk($sformatf("v%0d_ack_err", i),   {28'b0, bus.ack1, bus.ack2, bus.err1, bus.err2},
          {28'b0, vecs[i].ak1, vecs[i].ak2, vecs[i].er1, vecs[i].er2});
      chk($sformatf("v%0d_rdata1", i),    bus.rdata1, vecs[i].rd1);
      chk($sformatf("v%0d_rdata2", i),    bus.rdata2, vecs[i].rd2);
    end
    bus.mem_ready = 1'b0;

    // Starvation: both held; pattern is four port-2 grants then one port-1, twice
    bus.req1 = 1; bus.addr1 = 32'h400;
    bus.req2 = 1; bus.we2 = 0; bus.addr2 = 32'h500; bus.wdata2 = 0; bus.be2 = 4'hF;
    for (int g = 0; g < 10; g++) begin
      serve(port, 32'h1000 + g);
      chk($sformatf("starve_grant%0d", g), port, (g % 5 == 4) ? 32'd1 : 32'd2);
    end
    chk("starve_rdata1", bus.rdata1, 32'h1009);
    bus.req1 = 0; bus.req2 = 0;
    tick();

    // Timeout: port-2 read never answered
    bus.req2 = 1; bus.we2 = 0; bus.addr2 = 32'h600;
    tick();
    cnt = 0;
    while (bus.mem_req && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("tmo_mem_req_cycles", cnt, 16);
    chk("tmo_ack_err", {28'b0, bus.ack1, bus.ack2, bus.err1, bus.err2}, 32'b0101);
    chk("tmo_rdata2", bus.rdata2, 0);
    bus.req2 = 0;
    tick();
    chk("tmo_after", {28'b0, bus.ack1, bus.ack2, bus.err1, bus.err2}, 0);

    // Reset in the middle of a port-1 access
    bus.req1 = 1; bus.addr1 = 32'h700;
    tick();
    chk("rmid_granted", {31'b0, bus.mem_req}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid_async_mem_req", {31'b0, bus.mem_req}, 0);
    chk("rmid_async_be",      {28'b0, bus.mem_be}, 0);
    chk("rmid_async_rdata1",  bus.rdata1, 0);
    tick();
    chk("rmid_no_ack", {28'b0, bus.ack1, bus.ack2, bus.err1, bus.err2}, 0);
    rst_n = 1'b1;
    tick();
    chk("rmid_regrant_req",  {31'b0, bus.mem_req}, 1);
    chk("rmid_regrant_addr", bus.mem_addr, 32'h700);
    bus.mem_ready = 1; bus.mem_rdata = 32'h77777777;
    tick();
    bus.mem_ready = 0;
    chk("rmid_ack", {28'b0, bus.ack1, bus.ack2, bus.err1, bus.err2}, 32'b1000);
    chk("rmid_rdata1", bus.rdata1, 32'h77777777);
    bus.req1 = 0;
    tick();
    chk("rmid_ack_pulse", {31'b0, bus.ack1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/otter_mem_arb.md
OTTER_MEM_ARB -- requirements
Module: otter_mem_arb

Interface
REQ-001 Parameter ADDR_W, 32, requester/memory address width in bits.
REQ-002 Parameter TIMEOUT_CYC, 16, max cycles a memory access may wait for mem_ready (1..255).
REQ-003 Parameter STARVE_MAX, 4, consecutive port-2 grants allowed while port 1 waits (1..15).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 req1  input  1  port-1 (instruction fetch, read-only) request; held with addr1 until ack1.
REQ-007 addr1  input  ADDR_W  port-1 address.
REQ-008 rdata1, ack1, err1  output  32,1,1  port-1 read data, one-cycle completion pulse, timeout flag.
REQ-009 req2, we2  input  1,1  port-2 (data) request and write select; held with addr2/wdata2/be2 until ack2.
REQ-010 addr2, wdata2, be2  input  ADDR_W,32,4  port-2 address, write data, byte enables.
REQ-011 rdata2, ack2, err2  output  32,1,1  port-2 read data, completion pulse, timeout flag.
REQ-012 mem_req, mem_we  output  1,1  memory request (held until mem_ready) and write select.
REQ-013 mem_addr, mem_wdata, mem_be  output  ADDR_W,32,4  registered memory address, write data, byte enables.
REQ-014 mem_rdata, mem_ready  input  32,1  memory read data, valid when mem_ready=1; one-cycle ready pulse.

Function
REQ-015 FSM SHALL have states IDLE, GNT1, GNT2, DONE; all outputs registered.
REQ-016 IDLE: no req -> IDLE; only req1 -> GNT1; only req2 -> GNT2; both -> GNT2 unless starve count = STARVE_MAX, then GNT1.
REQ-017 On entry to GNTn, arbiter SHALL latch winner's addr/we/wdata/be into mem_* and set mem_req=1; port 1 drives mem_we=0, mem_be=4'hF, mem_wdata=0.
REQ-018 In GNTn, mem_* SHALL stay constant; mem_req=1 every cycle until mem_ready sampled 1.
REQ-019 mem_ready=1 in GNTn -> DONE; capture mem_rdata into rdataN (port 2 writes leave rdata2 unchanged), mem_req=0, ackN=1 for exactly the DONE cycle.
REQ-020 Wait counter SHALL clear on GNTn entry and increment each GNTn cycle without mem_ready; at TIMEOUT_CYC cycles -> DONE with ackN=1, errN=1, rdataN=32'h0, mem_req=0.
REQ-021 errN SHALL be high only during the DONE cycle of a timed-out access.
REQ-022 DONE -> IDLE unconditionally; requests ignored in DONE; at most one ack per cycle; ack1 and ack2 never both high.
REQ-023 Requester dropping req before ack is illegal; arbiter SHALL complete the granted access regardless.
REQ-024 Starve counter (4 bits): at an IDLE decision granting port 2 with req1=1, increment (saturate at STARVE_MAX); granting port 1 or req1=0 at decision, clear.
REQ-025 Minimum latency: req in IDLE cycle T, mem_req in T+1, mem_ready in T+1 -> ackN in T+2; back-to-back same-port access restarts no earlier than T+3.
REQ-026 mem_ready while in IDLE or DONE SHALL be ignored.

Reset
REQ-027 RST_N=0 SHALL immediately force IDLE, starve and wait counters 0, mem_req/mem_we/ack1/ack2/err1/err2 = 0, mem_addr/mem_wdata/rdata1/rdata2 = 0, mem_be=4'h0.
REQ-028 Reset during GNTn or DONE SHALL abort the access with no ack; first grant decision is in the first IDLE cycle after RST_N rises.

Verification
REQ-029 req1=1, addr1=0x100, mem_ready one cycle after mem_req with mem_rdata=0x12345678 -> ack1 pulse 2 cycles after req, rdata1=0x12345678, err1=0.
REQ-030 req1 and req2 (we2=1, addr2=0x200, wdata2=0xCAFEF00D, be2=4'h3) same cycle -> port 2 granted first with mem_we=1, mem_be=4'h3; port 1 served next.
REQ-031 req1 held, req2 reasserted every IDLE, STARVE_MAX=4 -> exactly 4 port-2 grants then a port-1 grant; counter then 0.
REQ-032 req2 read, mem_ready never asserted, TIMEOUT_CYC=16 -> mem_req high 16 cycles, then ack2=1, err2=1, rdata2=0 for one cycle.
REQ-033 RST_N pulled low mid-GNT1 -> mem_req=0 asynchronously, no ack1; after release req1 regranted and completes normally.
REQ-034 Spurious mem_ready in IDLE -> no ack, rdata1/rdata2 unchanged.
